// File: rtl/shift_rows_stage.sv
// Registered AES ShiftRows / InvShiftRows stage with valid/ready handshakes
// and a two-entry output/skid buffer carrying a round tag with each state.
module shift_rows_stage #(
    parameter int TAG_W  = 4,
    parameter int INV_EN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0][7:0]       state,
    input  logic [TAG_W-1:0]       in_round,
    input  logic                   inverse,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0][7:0]       newstate,
    output logic [TAG_W-1:0]       out_round,
    output logic [1:0]             occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } fsm_t;

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [1:0]         r_occ;
    logic [15:0][7:0]   r_out_data;
    logic [TAG_W-1:0]   r_out_tag;
    logic [15:0][7:0]   r_skd_data;
    logic [TAG_W-1:0]   r_skd_tag;

    logic               w_acc;
    logic               w_emit;
    logic               w_inv;
    logic               w_out_from_in;
    logic               w_out_from_skd;
    logic               w_skd_from_in;
    logic [15:0][7:0]   w_shifted;

    // Byte for row r, column c lives at index 15-4c-r.
    function automatic logic [15:0][7:0] shift_rows(input logic [15:0][7:0] s,
                                                    input logic inv);
        logic [15:0][7:0] o;
        int unsigned      src;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[15 - 4*c - r] = s[15 - 4*src - r];
            end
        end
        return o;
    endfunction

    assign w_inv     = (INV_EN != 0) && inverse;
    assign w_shifted = shift_rows(state, w_inv);
    assign w_acc     = in_valid && r_in_ready;
    assign w_emit    = r_out_valid && out_ready;

    // State register; handshake flags and occupancy are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_in_ready  <= (w_fsm_nxt != S_FULL);
            r_out_valid <= (w_fsm_nxt != S_EMPTY);
            case (w_fsm_nxt)
                S_EMPTY: r_occ <= 2'd0;
                S_ONE:   r_occ <= 2'd1;
                default: r_occ <= 2'd2;
            endcase
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_EMPTY: if (w_acc) w_fsm_nxt = S_ONE;
            S_ONE: begin
                if (w_acc && !w_emit)      w_fsm_nxt = S_FULL;
                else if (w_emit && !w_acc) w_fsm_nxt = S_EMPTY;
            end
            S_FULL:  if (w_emit) w_fsm_nxt = S_ONE;
            default: w_fsm_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        w_out_from_in  = 1'b0;
        w_skd_from_in  = 1'b0;
        w_out_from_skd = 1'b0;
        case (r_fsm)
            S_EMPTY: w_out_from_in = w_acc;
            S_ONE: begin
                w_out_from_in = w_acc && w_emit;
                w_skd_from_in = w_acc && !w_emit;
            end
            S_FULL:  w_out_from_skd = w_emit;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_skd_data <= '0;
            r_skd_tag  <= '0;
        end else begin
            if (w_out_from_in) begin
                r_out_data <= w_shifted;
                r_out_tag  <= in_round;
            end else if (w_out_from_skd) begin
                r_out_data <= r_skd_data;
                r_out_tag  <= r_skd_tag;
            end
            if (w_skd_from_in) begin
                r_skd_data <= w_shifted;
                r_skd_tag  <= in_round;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occupancy = r_occ;
    assign newstate  = r_out_data;
    assign out_round = r_out_tag;

endmodule

// File: tb/tb_shift_rows_stage.sv
// Directed and random-stall bench for shift_rows_stage; a second instance
// with the inverse path disabled covers the forward-only build.
module tb_shift_rows_stage;

    typedef logic [15:0][7:0] st_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    st_t         state;
    logic [3:0]  in_round;
    logic        inverse;
    logic        out_valid;
    logic        out_ready;
    st_t         newstate;
    logic [3:0]  out_round;
    logic [1:0]  occupancy;

    logic        n_in_ready;
    logic        n_out_valid;
    st_t         n_newstate;
    logic [3:0]  n_out_round;
    logic [1:0]  n_occupancy;

    int errors = 0;
    int checks = 0;

    st_t vec_in;
    st_t vec_fwd;
    st_t vec_fwd2;

    always #5 clk = ~clk;

    shift_rows_stage #(.TAG_W(4), .INV_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .state(state), .in_round(in_round), .inverse(inverse),
        .out_valid(out_valid), .out_ready(out_ready), .newstate(newstate),
        .out_round(out_round), .occupancy(occupancy)
    );

    shift_rows_stage #(.TAG_W(4), .INV_EN(0)) dut_fwd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
        .state(state), .in_round(in_round), .inverse(inverse),
        .out_valid(n_out_valid), .out_ready(out_ready), .newstate(n_newstate),
        .out_round(n_out_round), .occupancy(n_occupancy)
    );

    // Rows are given as 32-bit words, column 0 in the top byte.
    function automatic st_t mk(input logic [31:0] r0, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] r3);
        logic [31:0] rw [4];
        st_t s;
        rw[0] = r0; rw[1] = r1; rw[2] = r2; rw[3] = r3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[15 - 4*c - r] = rw[r][31 - 8*c -: 8];
        return s;
    endfunction

    // Reference: forward rotates each row word left by r bytes, inverse right.
    function automatic st_t ref_shift(input st_t s, input logic inv);
        st_t         o;
        logic [31:0] w;
        logic [63:0] d;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) w[31 - 8*c -: 8] = s[15 - 4*c - r];
            d = {w, w};
            w = inv ? d[31 + 8*r -: 32] : d[63 - 8*r -: 32];
            for (int c = 0; c < 4; c++) o[15 - 4*c - r] = w[31 - 8*c -: 8];
        end
        return o;
    endfunction

    task test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        state = '0; in_round = '0; inverse = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (newstate !== '0) begin errors++; $display("FAIL reset_newstate got=%h exp=0", newstate); end
        checks++; if (out_round !== 4'd0) begin errors++; $display("FAIL reset_out_round got=%0d exp=0", out_round); end
    endtask

    task test_forward();
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; state = vec_in; in_round = 4'd1; inverse = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_out_valid got=%b exp=1", out_valid); end
        checks++; if (newstate !== vec_fwd) begin errors++; $display("FAIL fwd_newstate got=%h exp=%h", newstate, vec_fwd); end
        checks++; if (out_round !== 4'd1) begin errors++; $display("FAIL fwd_out_round got=%0d exp=1", out_round); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drained got=%b exp=0", out_valid); end
    endtask

    task test_inverse();
        in_valid = 1'b1; state = vec_fwd; in_round = 4'd2; inverse = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; inverse = 1'b0;
        @(negedge clk);
        checks++; if (newstate !== vec_in) begin errors++; $display("FAIL inv_newstate got=%h exp=%h", newstate, vec_in); end
        checks++; if (out_round !== 4'd2) begin errors++; $display("FAIL inv_out_round got=%0d exp=2", out_round); end
        checks++; if (n_newstate !== vec_fwd2) begin errors++; $display("FAIL inv_disabled_newstate got=%h exp=%h", n_newstate, vec_fwd2); end
        checks++; if (n_out_valid !== 1'b1) begin errors++; $display("FAIL inv_disabled_valid got=%b exp=1", n_out_valid); end
        @(posedge clk); #1;
    endtask

    task test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; state = vec_in; in_round = 4'd3; inverse = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_first got=%b exp=1", in_ready); end
        state = vec_fwd; in_round = 4'd4;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_second got=%b exp=0", in_ready); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occupancy_full got=%0d exp=2", occupancy); end
        state = vec_fwd2; in_round = 4'd5;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_third_ignored got=%0d exp=2", occupancy); end
        checks++; if (out_round !== 4'd3) begin errors++; $display("FAIL bp_head_stable got=%0d exp=3", out_round); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_round !== 4'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_out got=%0d/%b exp=3/1", out_round, out_valid); end
        @(negedge clk);
        checks++; if (out_round !== 4'd4 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_out got=%0d/%b exp=4/1", out_round, out_valid); end
        checks++; if (newstate !== ref_shift(vec_fwd, 1'b0)) begin errors++; $display("FAIL bp_second_data got=%h", newstate); end
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_occ_one got=%0d/%b exp=1/1", occupancy, in_ready); end
        @(negedge clk);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0d/%b exp=0/0", occupancy, out_valid); end
        @(posedge clk); #1;
    endtask

    task test_back_to_back();
        st_t s;
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; in_round = 4'(k); inverse = 1'b0;
                state = mk(32'h00112233 ^ 32'(k), 32'h44556677 ^ (32'(k) << 8),
                           32'h8899aabb ^ (32'(k) << 16), 32'hccddeeff ^ (32'(k) << 24));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, in_ready); end
            end
            if (k == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_pre_valid got=%b exp=0", out_valid); end
            end else begin
                s = mk(32'h00112233 ^ 32'(k-1), 32'h44556677 ^ (32'(k-1) << 8),
                       32'h8899aabb ^ (32'(k-1) << 16), 32'hccddeeff ^ (32'(k-1) << 24));
                checks++;
                if (out_valid !== 1'b1 || out_round !== 4'(k-1) || newstate !== ref_shift(s, 1'b0)) begin
                    errors++;
                    $display("FAIL stream_out k=%0d got=%b/%0d exp=1/%0d", k, out_valid, out_round, k-1);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task test_random_stall();
        st_t        q_data[$];
        logic [3:0] q_tag[$];
        st_t        held_s;
        logic [3:0] held_t;
        bit         hold = 0;
        bit         acc, emit;
        int         sent = 0, rcvd = 0, cyc = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        while (rcvd < 100 && cyc < 3000) begin
            @(negedge clk);
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || newstate !== held_s || out_round !== held_t) begin
                    errors++;
                    $display("FAIL rand_stable cyc=%0d got=%0d exp=%0d", cyc, out_round, held_t);
                end
            end
            hold   = out_valid && !out_ready;
            held_s = newstate;
            held_t = out_round;
            if (emit) begin
                checks++;
                if (q_data.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected cyc=%0d got=%0d exp=none", cyc, out_round);
                end else begin
                    if (newstate !== q_data[0] || out_round !== q_tag[0]) begin
                        errors++;
                        $display("FAIL rand_order n=%0d got=%0d/%h exp=%0d/%h", rcvd, out_round, newstate, q_tag[0], q_data[0]);
                    end
                    void'(q_data.pop_front());
                    void'(q_tag.pop_front());
                end
                rcvd++;
            end
            if (acc) begin
                q_data.push_back(ref_shift(state, inverse));
                q_tag.push_back(in_round);
                sent++;
            end
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                if (sent < 100 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    state    = mk($urandom, $urandom, $urandom, $urandom);
                    in_round = 4'(sent);
                    inverse  = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cyc++;
        end
        checks++;
        if (rcvd < 100) begin errors++; $display("FAIL rand_timeout got=%0d exp=100", rcvd); end
        in_valid = 1'b0; inverse = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; state = vec_in; in_round = 4'd1;
        @(posedge clk); #1;
        in_round = 4'd2;
        @(posedge clk); #1;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rst_mid_full got=%0d exp=2", occupancy); end
        reset = 1'b1; in_round = 4'd10; state = vec_fwd;
        @(negedge clk);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_mid_occ got=%0d exp=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        checks++; if (newstate !== '0 || out_round !== 4'd0) begin errors++; $display("FAIL rst_mid_data got=%h/%0d exp=0/0", newstate, out_round); end
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; state = vec_in; in_round = 4'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_round !== 4'd9 || newstate !== vec_fwd) begin
            errors++; $display("FAIL rst_mid_next got=%b/%0d exp=1/9", out_valid, out_round);
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL rst_mid_stale got=%b/%0d exp=0/0", out_valid, occupancy);
        end
    endtask

    initial begin
        vec_in   = mk(32'hd4e0b81e, 32'h27bfb441, 32'h11985d52, 32'haef1e530);
        vec_fwd  = mk(32'hd4e0b81e, 32'hbfb44127, 32'h5d521198, 32'h30aef1e5);
        vec_fwd2 = mk(32'hd4e0b81e, 32'hb44127bf, 32'h11985d52, 32'he530aef1);
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
